// File: rtl/time_setter_seq_pkg.sv
// ---------------------------------------------------------------------------
// time_setter_seq_pkg
// Shared definitions for the time setter: time-word field ranges, button bit
// positions on the 7-bit button bus, field moduli, FSM state encoding and the
// small arithmetic helpers used to pick a press direction.
// ---------------------------------------------------------------------------
package time_setter_seq_pkg;

  // Field bit ranges inside the 18-bit time word {hh, mm, ss}
  localparam int HOUR_MSB = 17;
  localparam int HOUR_LSB = 12;
  localparam int MIN_MSB  = 11;
  localparam int MIN_LSB  = 6;
  localparam int SEC_MSB  = 5;
  localparam int SEC_LSB  = 0;

  // Button bus bit positions {IHOUR, DHOUR, IMIN, DMIN, ISEC, DSEC, RESET_TIME}
  localparam int B_IHOUR = 6;
  localparam int B_DHOUR = 5;
  localparam int B_IMIN  = 4;
  localparam int B_DMIN  = 3;
  localparam int B_ISEC  = 2;
  localparam int B_DSEC  = 1;
  localparam int B_RESET = 0;

  // Field moduli, 7 bits wide so the wrapped distance never overflows
  localparam logic [6:0] MOD_HOUR   = 7'd24;
  localparam logic [6:0] MOD_MINSEC = 7'd60;

  // Main FSM encoding; HOUR/MIN/SEC are the compare substates of each field,
  // PRESS/GAP are shared by all three fields (return field kept separately)
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_CLR    = 4'd1;
  localparam logic [3:0] ST_HOUR   = 4'd2;
  localparam logic [3:0] ST_MIN    = 4'd3;
  localparam logic [3:0] ST_SEC    = 4'd4;
  localparam logic [3:0] ST_PRESS  = 4'd5;
  localparam logic [3:0] ST_GAP    = 4'd6;
  localparam logic [3:0] ST_VERIFY = 4'd7;

  // Forward distance (tgt - cur) mod m with an explicit wrap instead of '%'
  function automatic logic [6:0] fwd_dist(input logic [5:0] tgt,
                                          input logic [5:0] cur,
                                          input logic [6:0] m);
    logic [6:0] t7;
    logic [6:0] c7;
    t7 = {1'b0, tgt};
    c7 = {1'b0, cur};
    if (t7 >= c7) begin
      return t7 - c7;
    end else begin
      return (t7 + m) - c7;
    end
  endfunction

  // A target is settable only if every field is inside its modulus
  function automatic logic time_valid(input logic [17:0] t);
    return (t[HOUR_MSB:HOUR_LSB] < 6'd24) &&
           (t[MIN_MSB:MIN_LSB]   < 6'd60) &&
           (t[SEC_MSB:SEC_LSB]   < 6'd60);
  endfunction

  // One-hot button word for a given bit position
  function automatic logic [6:0] btn_onehot(input int idx);
    logic [6:0] r;
    r = 7'd1 << idx;
    return r;
  endfunction

endpackage

// File: rtl/time_setter_seq_press_gen.sv
// ---------------------------------------------------------------------------
// time_setter_seq_press_gen
// Issues one button press: on go, the one-hot request is driven for PULSE_LEN
// cycles, then the bus stays low for GAP_LEN cycles, then ready pulses for
// one cycle. go is only honoured while idle.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset (bus drops to 0 at once)
//   go     in   single-cycle start strobe
//   req    in   7-bit one-hot button request
//   btn    out  7-bit registered button bus
//   ready  out  one-cycle pulse when press and settle gap are complete
// ---------------------------------------------------------------------------
module time_setter_seq_press_gen #(
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [6:0] req,
  output logic [6:0] btn,
  output logic       ready
);

  localparam logic [1:0] PG_IDLE = 2'd0;
  localparam logic [1:0] PG_HOLD = 2'd1;
  localparam logic [1:0] PG_GAP  = 2'd2;

  localparam logic [15:0] PULSE_LAST = 16'(PULSE_LEN - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_LEN - 1);

  logic [1:0]  state_r;
  logic [15:0] cnt_r;
  logic [6:0]  btn_r;
  logic        ready_r;

  // Press sequencer: hold phase, settle phase, ready strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= PG_IDLE;
      cnt_r   <= 16'd0;
      btn_r   <= 7'd0;
      ready_r <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      case (state_r)
        PG_IDLE: begin
          if (go) begin
            btn_r   <= req;
            cnt_r   <= 16'd0;
            state_r <= PG_HOLD;
          end
        end
        PG_HOLD: begin
          if (cnt_r == PULSE_LAST) begin
            btn_r   <= 7'd0;
            cnt_r   <= 16'd0;
            state_r <= PG_GAP;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        PG_GAP: begin
          if (cnt_r == GAP_LAST) begin
            ready_r <= 1'b1;
            cnt_r   <= 16'd0;
            state_r <= PG_IDLE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          btn_r   <= 7'd0;
          cnt_r   <= 16'd0;
          state_r <= PG_IDLE;
        end
      endcase
    end
  end

  assign btn   = btn_r;
  assign ready = ready_r;

endmodule

// File: rtl/time_setter_seq.sv
// ---------------------------------------------------------------------------
// time_setter_seq
// Drives the increment/decrement button bus of a running clock until its
// CURR_TIME equals a requested TARGET. Fields are adjusted hour, minute,
// second in turn, each press choosing the shorter way round the dial, and
// the whole time word is verified at the end (retrying if the clock ticked).
// Ports:
//   CLK        in   clock, rising edge
//   RESET      in   asynchronous active-high reset
//   START      in   single-cycle request, sampled only when idle
//   TARGET     in   18-bit requested time {hh, mm, ss}, binary
//   CURR_TIME  in   18-bit running time from the time handler
//   BUTTONS    out  {IHOUR, DHOUR, IMIN, DMIN, ISEC, DSEC, RESET_TIME}
//   BUSY       out  high while a set operation is in progress
//   DONE       out  one-cycle pulse on successful verify
//   ERR        out  one-cycle pulse on invalid target or press budget spent
// ---------------------------------------------------------------------------
module time_setter_seq
  import time_setter_seq_pkg::*;
#(
  parameter int PULSE_LEN   = 2,
  parameter int GAP_LEN     = 4,
  parameter int MAX_PRESSES = 64,
  parameter int USE_CLEAR   = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [17:0] TARGET,
  input  logic [17:0] CURR_TIME,
  output logic [6:0]  BUTTONS,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam int              CNT_W   = $clog2(MAX_PRESSES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PRESSES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       state_r;
  logic [3:0]       field_r;      // compare state to return to after a press
  logic [17:0]      tgt_r;
  logic [CNT_W-1:0] press_cnt_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic             pg_go_r;
  logic [6:0]       pg_req_r;

  logic [6:0]       pg_btn_s;
  logic             pg_ready_s;

  logic [5:0]       cur_f_s;
  logic [5:0]       tgt_f_s;
  logic [6:0]       mod_s;
  logic [6:0]       inc_s;
  logic [6:0]       dec_s;
  logic [6:0]       dist_s;
  logic [6:0]       sel_s;
  logic             field_eq_s;
  logic [3:0]       next_field_s;

  time_setter_seq_press_gen #(
    .PULSE_LEN (PULSE_LEN),
    .GAP_LEN   (GAP_LEN)
  ) u_press_gen (
    .clk   (CLK),
    .rst   (RESET),
    .go    (pg_go_r),
    .req   (pg_req_r),
    .btn   (pg_btn_s),
    .ready (pg_ready_s)
  );

  // Field view for the current compare state: values, modulus, buttons
  always_comb begin
    cur_f_s      = 6'd0;
    tgt_f_s      = 6'd0;
    mod_s        = MOD_MINSEC;
    inc_s        = 7'd0;
    dec_s        = 7'd0;
    next_field_s = ST_VERIFY;
    case (state_r)
      ST_HOUR: begin
        cur_f_s      = CURR_TIME[HOUR_MSB:HOUR_LSB];
        tgt_f_s      = tgt_r[HOUR_MSB:HOUR_LSB];
        mod_s        = MOD_HOUR;
        inc_s        = btn_onehot(B_IHOUR);
        dec_s        = btn_onehot(B_DHOUR);
        next_field_s = ST_MIN;
      end
      ST_MIN: begin
        cur_f_s      = CURR_TIME[MIN_MSB:MIN_LSB];
        tgt_f_s      = tgt_r[MIN_MSB:MIN_LSB];
        mod_s        = MOD_MINSEC;
        inc_s        = btn_onehot(B_IMIN);
        dec_s        = btn_onehot(B_DMIN);
        next_field_s = ST_SEC;
      end
      ST_SEC: begin
        cur_f_s      = CURR_TIME[SEC_MSB:SEC_LSB];
        tgt_f_s      = tgt_r[SEC_MSB:SEC_LSB];
        mod_s        = MOD_MINSEC;
        inc_s        = btn_onehot(B_ISEC);
        dec_s        = btn_onehot(B_DSEC);
        next_field_s = ST_VERIFY;
      end
      default: begin
        next_field_s = ST_VERIFY;
      end
    endcase
    field_eq_s = (cur_f_s == tgt_f_s);
    dist_s     = fwd_dist(tgt_f_s, cur_f_s, mod_s);
    // Half-way ties go forward
    if (dist_s <= (mod_s >> 1)) begin
      sel_s = inc_s;
    end else begin
      sel_s = dec_s;
    end
  end

  // Main sequencer: accept, optional clear, per-field adjust, verify
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      field_r     <= ST_HOUR;
      tgt_r       <= 18'd0;
      press_cnt_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      pg_go_r     <= 1'b0;
      pg_req_r    <= 7'd0;
    end else begin
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      pg_go_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            tgt_r <= TARGET;
            if (!time_valid(TARGET)) begin
              err_r <= 1'b1;
            end else begin
              busy_r      <= 1'b1;
              press_cnt_r <= '0;
              if (USE_CLEAR != 0) begin
                pg_go_r  <= 1'b1;
                pg_req_r <= btn_onehot(B_RESET);
                state_r  <= ST_CLR;
              end else begin
                state_r <= ST_HOUR;
              end
            end
          end
        end
        ST_CLR: begin
          if (pg_ready_s) begin
            state_r <= ST_HOUR;
          end
        end
        ST_HOUR, ST_MIN, ST_SEC: begin
          if (field_eq_s) begin
            state_r <= next_field_s;
          end else begin
            pg_req_r <= sel_s;
            field_r  <= state_r;
            state_r  <= ST_PRESS;
          end
        end
        ST_PRESS: begin
          // Budget is checked before a press is issued, so exactly
          // MAX_PRESSES presses can happen in one operation
          if (press_cnt_r >= MAX_CNT) begin
            err_r   <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            pg_go_r     <= 1'b1;
            press_cnt_r <= press_cnt_r + CNT_ONE;
            state_r     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (pg_ready_s) begin
            state_r <= field_r;
          end
        end
        ST_VERIFY: begin
          // A tick or carry during adjustment restarts from hours,
          // keeping the press count so the budget still bounds retries
          if (CURR_TIME == tgt_r) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_HOUR;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUTTONS = pg_btn_s;
  assign BUSY    = busy_r;
  assign DONE    = done_r;
  assign ERR     = err_r;

endmodule

// File: tb/tb_time_setter_seq.sv
// ---------------------------------------------------------------------------
// tb_time_setter_seq
// Directed bench for time_setter_seq with a behavioural time-handler model
// that reacts to rising edges on the button bus and can tick seconds.
// ---------------------------------------------------------------------------
module tb_time_setter_seq;

  localparam int PULSE_LEN   = 2;
  localparam int GAP_LEN     = 4;
  localparam int MAX_PRESSES = 8;
  localparam int USE_CLEAR   = 0;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [17:0] TARGET = 18'd0;
  logic [17:0] curr;
  logic [6:0]  BUTTONS;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int checks = 0;
  int errors = 0;

  time_setter_seq #(
    .PULSE_LEN   (PULSE_LEN),
    .GAP_LEN     (GAP_LEN),
    .MAX_PRESSES (MAX_PRESSES),
    .USE_CLEAR   (USE_CLEAR)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .TARGET    (TARGET),
    .CURR_TIME (curr),
    .BUTTONS   (BUTTONS),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  // ---------------- time handler model ----------------
  logic        preset_en = 1'b1;
  logic [17:0] preset_val = 18'd0;
  logic        tick_en = 1'b0;
  int          tick_c = 0;
  logic [6:0]  prev_h = 7'd0;

  function automatic logic [17:0] model_next(input logic [17:0] t,
                                             input logic [6:0] rise,
                                             input logic tick);
    int h;
    int m;
    int s;
    h = int'(t[17:12]);
    m = int'(t[11:6]);
    s = int'(t[5:0]);
    if (rise[6]) h = (h + 1) % 24;
    if (rise[5]) h = (h + 23) % 24;
    if (rise[4]) m = (m + 1) % 60;
    if (rise[3]) m = (m + 59) % 60;
    if (rise[2]) s = (s + 1) % 60;
    if (rise[1]) s = (s + 59) % 60;
    if (rise[0]) begin h = 0; m = 0; s = 0; end
    if (tick) begin
      s = s + 1;
      if (s == 60) begin
        s = 0;
        m = m + 1;
        if (m == 60) begin
          m = 0;
          h = (h + 1) % 24;
        end
      end
    end
    return {6'(h), 6'(m), 6'(s)};
  endfunction

  always @(posedge CLK) begin
    prev_h <= BUTTONS;
    if (preset_en) begin
      curr   <= preset_val;
      tick_c <= 0;
    end else begin
      curr   <= model_next(curr, BUTTONS & ~prev_h, tick_en && (tick_c == 4));
      tick_c <= (tick_c == 4) ? 0 : tick_c + 1;
    end
  end

  // ---------------- bus monitor ----------------
  int         pcnt [0:6];
  int         wid  [0:6];
  int         log_a [0:255];
  int         log_n = 0;
  int         width_bad = 0;
  int         viol = 0;
  int         done_n = 0;
  int         err_n = 0;
  int         both_n = 0;
  logic [6:0] prev_m = 7'd0;

  always @(negedge CLK) begin
    prev_m <= BUTTONS;
    for (int b = 0; b < 7; b++) begin
      if (BUTTONS[b] && !prev_m[b]) begin
        pcnt[b] <= pcnt[b] + 1;
        wid[b]  <= 1;
        if (log_n < 256) log_a[log_n] <= b;
        log_n <= log_n + 1;
      end else if (BUTTONS[b]) begin
        wid[b] <= wid[b] + 1;
      end else if (prev_m[b] && (wid[b] != PULSE_LEN)) begin
        width_bad <= width_bad + 1;
      end
    end
    if ((BUTTONS & (BUTTONS - 7'd1)) != 7'd0) viol <= viol + 1;
    if (DONE) done_n <= done_n + 1;
    if (ERR) err_n <= err_n + 1;
    if (DONE && ERR) both_n <= both_n + 1;
  end

  // ---------------- snapshots ----------------
  int s_p [0:6];
  int s_log, s_wb, s_done, s_err;

  task automatic take_snap();
    for (int b = 0; b < 7; b++) s_p[b] = pcnt[b];
    s_log  = log_n;
    s_wb   = width_bad;
    s_done = done_n;
    s_err  = err_n;
  endtask

  function automatic int dp(input int b);
    return pcnt[b] - s_p[b];
  endfunction

  function automatic int dtot();
    int t;
    t = 0;
    for (int b = 0; b < 7; b++) t = t + (pcnt[b] - s_p[b]);
    return t;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic preset(input logic [17:0] v, input logic tk);
    @(posedge CLK); #1;
    preset_val = v;
    preset_en  = 1'b1;
    tick_en    = tk;
    @(posedge CLK); #1;
    preset_en  = 1'b0;
  endtask

  task automatic start_op(input logic [17:0] tgt);
    @(posedge CLK); #1;
    TARGET = tgt;
    START  = 1'b1;
    @(posedge CLK); #1;
    START  = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!(DONE || ERR) && (n < max_cyc)) begin
      @(posedge CLK); #1;
      n++;
    end
    chk({tag, "_end"}, {31'd0, DONE | ERR}, 32'd1);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  // Field setter helper for readable targets
  function automatic logic [17:0] hms(input int h, input int m, input int s);
    return {6'(h), 6'(m), 6'(s)};
  endfunction

  int exp1 [0:5] = '{6, 4, 4, 2, 2, 2};

  initial begin
    // ---- reset state (async) ----
    #1;
    chk("rst_buttons", 32'(BUTTONS), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    chk("idle_busy", 32'(BUSY), 32'd0);

    // ---- T1: 00:00:00 -> 01:02:03 ----
    preset(hms(0, 0, 0), 1'b0);
    take_snap();
    start_op(hms(1, 2, 3));
    chk("t1_busy", 32'(BUSY), 32'd1);
    wait_end("t1", 400);
    chk("t1_ihour", 32'(dp(6)), 32'd1);
    chk("t1_imin", 32'(dp(4)), 32'd2);
    chk("t1_isec", 32'(dp(2)), 32'd3);
    chk("t1_total", 32'(dtot()), 32'd6);
    for (int i = 0; i < 6; i++) chk("t1_order", 32'(log_a[s_log + i]), 32'(exp1[i]));
    chk("t1_width", 32'(width_bad - s_wb), 32'd0);
    chk("t1_done", 32'(done_n - s_done), 32'd1);
    chk("t1_err", 32'(err_n - s_err), 32'd0);
    chk("t1_busy_end", 32'(BUSY), 32'd0);
    chk("t1_time", 32'(curr), 32'(hms(1, 2, 3)));

    // ---- T2: forward wrap 23:59:59 -> 00:00:00 ----
    preset(hms(23, 59, 59), 1'b0);
    take_snap();
    start_op(hms(0, 0, 0));
    wait_end("t2", 400);
    chk("t2_ihour", 32'(dp(6)), 32'd1);
    chk("t2_imin", 32'(dp(4)), 32'd1);
    chk("t2_isec", 32'(dp(2)), 32'd1);
    chk("t2_total", 32'(dtot()), 32'd3);
    chk("t2_done", 32'(done_n - s_done), 32'd1);
    chk("t2_time", 32'(curr), 32'd0);

    // ---- T3: backward 00:00:00 -> 23:58:00 ----
    preset(hms(0, 0, 0), 1'b0);
    take_snap();
    start_op(hms(23, 58, 0));
    wait_end("t3", 400);
    chk("t3_dhour", 32'(dp(5)), 32'd1);
    chk("t3_dmin", 32'(dp(3)), 32'd2);
    chk("t3_sec", 32'(dp(2) + dp(1)), 32'd0);
    chk("t3_total", 32'(dtot()), 32'd3);
    chk("t3_done", 32'(done_n - s_done), 32'd1);
    chk("t3_time", 32'(curr), 32'(hms(23, 58, 0)));

    // ---- T4: invalid targets ----
    take_snap();
    start_op(hms(24, 0, 0));
    chk("t4h_err", 32'(ERR), 32'd1);
    chk("t4h_busy", 32'(BUSY), 32'd0);
    chk("t4h_buttons", 32'(BUTTONS), 32'd0);
    start_op(hms(0, 60, 0));
    chk("t4m_err", 32'(ERR), 32'd1);
    chk("t4m_busy", 32'(BUSY), 32'd0);
    repeat (10) @(posedge CLK);
    #1;
    chk("t4_presses", 32'(dtot()), 32'd0);
    chk("t4_errs", 32'(err_n - s_err), 32'd2);
    chk("t4_done", 32'(done_n - s_done), 32'd0);

    // ---- T5: tie goes forward, budget of 8 presses exhausted ----
    preset(hms(0, 0, 0), 1'b0);
    take_snap();
    start_op(hms(0, 30, 0));
    wait_end("t5", 400);
    chk("t5_imin", 32'(dp(4)), 32'd8);
    chk("t5_dmin", 32'(dp(3)), 32'd0);
    chk("t5_err", 32'(err_n - s_err), 32'd1);
    chk("t5_done", 32'(done_n - s_done), 32'd0);
    chk("t5_busy", 32'(BUSY), 32'd0);
    chk("t5_min", 32'(curr[11:6]), 32'd8);

    // ---- T6: ticking clock, retry or budget error ----
    preset(hms(0, 0, 0), 1'b1);
    take_snap();
    start_op(hms(0, 0, 10));
    wait_end("t6", 600);
    tick_en = 1'b0;
    chk("t6_outcome", 32'((done_n - s_done) + (err_n - s_err)), 32'd1);
    chk("t6_budget", 32'(dtot() <= MAX_PRESSES), 32'd1);
    chk("t6_busy", 32'(BUSY), 32'd0);

    // ---- T7: reset in the middle of an IMIN press ----
    preset(hms(0, 0, 0), 1'b0);
    start_op(hms(0, 5, 0));
    for (int n = 0; n < 200; n++) begin
      if (BUTTONS[4]) break;
      @(posedge CLK); #1;
    end
    chk("t7_seen_imin", 32'(BUTTONS[4]), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    chk("t7_rst_buttons", 32'(BUTTONS), 32'd0);
    chk("t7_rst_busy", 32'(BUSY), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    take_snap();
    start_op(hms(0, 0, 1));
    wait_end("t7", 400);
    chk("t7_isec", 32'(dp(2)), 32'd1);
    chk("t7_total", 32'(dtot()), 32'd1);
    chk("t7_done", 32'(done_n - s_done), 32'd1);
    chk("t7_time", 32'(curr), 32'(hms(0, 0, 1)));

    // ---- global properties ----
    chk("onehot", 32'(viol), 32'd0);
    chk("done_err_same", 32'(both_n), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
